// File: rtl/polar_to_rect_cordic.sv
// polar_to_rect_cordic: pipelined rotation-mode CORDIC, (amplitude, angle) -> (real, imag).
// Angle units: 10000 = PI, signed. 12 iterations with a fixed arctan table.
// Optional build macro GAIN_COMP_EN adds a registered stage that removes the CORDIC
// gain (x, y scaled by 19898/32768); without it outputs carry gain K ~1.6468.
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - asynchronous active-high reset
//   inValid  - qualifies ampIn/angleIn
//   ampIn    - magnitude (signed, driven >= 0)
//   angleIn  - phase, legal range -10000..+10000
//   outValid - one-cycle strobe when realOut/imagOut update
//   realOut  - cosine component
//   imagOut  - sine component
module polar_to_rect_cordic #(
    parameter int AMPWIDTH   = 20,
    parameter int ANGLEWIDTH = 15,
    parameter int MIDWIDTH   = 22,
    parameter int OUTWIDTH   = 22,
    parameter int STAGES     = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       inValid,
    input  logic signed [AMPWIDTH-1:0]   ampIn,
    input  logic signed [ANGLEWIDTH-1:0] angleIn,
    output logic                       outValid,
    output logic signed [OUTWIDTH-1:0] realOut,
    output logic signed [OUTWIDTH-1:0] imagOut
);

    // One spare bit on z so pre-rotate offsets never wrap, even for illegal angles.
    localparam int ZW = ANGLEWIDTH + 1;
    localparam logic signed [ZW-1:0] QUARTER     = ZW'(5000);
    localparam logic signed [ZW-1:0] NEG_QUARTER = -ZW'(5000);

`ifdef GAIN_COMP_EN
    localparam int VDEPTH = STAGES + 1;
`else
    localparam int VDEPTH = STAGES;
`endif

    function automatic logic signed [ZW-1:0] atan_lut(input int i);
        case (i)
            0:       atan_lut = ZW'(2500);
            1:       atan_lut = ZW'(1476);
            2:       atan_lut = ZW'(780);
            3:       atan_lut = ZW'(396);
            4:       atan_lut = ZW'(199);
            5:       atan_lut = ZW'(99);
            6:       atan_lut = ZW'(50);
            7:       atan_lut = ZW'(25);
            8:       atan_lut = ZW'(12);
            9:       atan_lut = ZW'(6);
            10:      atan_lut = ZW'(3);
            11:      atan_lut = ZW'(2);
            default: atan_lut = '0;
        endcase
    endfunction

    logic signed [MIDWIDTH-1:0] amp_ext;
    logic signed [ZW-1:0]       ang_ext;
    logic signed [MIDWIDTH-1:0] pre_x, pre_y;
    logic signed [ZW-1:0]       pre_z;

    // Stage k consumes x_q[k]/y_q[k]/z_q[k]; x_q[0] is the pre-rotate register.
    logic signed [MIDWIDTH-1:0] x_q [STAGES];
    logic signed [MIDWIDTH-1:0] y_q [STAGES];
    logic signed [ZW-1:0]       z_q [STAGES];
    logic signed [MIDWIDTH-1:0] x_n [STAGES];
    logic signed [MIDWIDTH-1:0] y_n [STAGES];
    logic [VDEPTH-1:0]          vld_q;
    logic signed [MIDWIDTH-1:0] res_x, res_y;

    assign amp_ext = MIDWIDTH'(ampIn);
    assign ang_ext = ZW'(angleIn);

    // Fold |angle| > PI/2 into the convergence range of the iterations.
    always_comb begin
        pre_x = amp_ext;
        pre_y = '0;
        pre_z = ang_ext;
        if (ang_ext > QUARTER) begin
            pre_x = '0;
            pre_y = amp_ext;
            pre_z = ang_ext - QUARTER;
        end else if (ang_ext < NEG_QUARTER) begin
            pre_x = '0;
            pre_y = -amp_ext;
            pre_z = ang_ext + QUARTER;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (!z_q[k][ZW-1]) begin
                x_n[k] = x_q[k] - (y_q[k] >>> k);
                y_n[k] = y_q[k] + (x_q[k] >>> k);
            end else begin
                x_n[k] = x_q[k] + (y_q[k] >>> k);
                y_n[k] = y_q[k] - (x_q[k] >>> k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
                z_q[k] <= '0;
            end
            vld_q <= '0;
        end else begin
            x_q[0] <= pre_x;
            y_q[0] <= pre_y;
            z_q[0] <= pre_z;
            for (int k = 1; k < STAGES; k++) begin
                x_q[k] <= x_n[k-1];
                y_q[k] <= y_n[k-1];
                z_q[k] <= z_q[k-1][ZW-1] ? z_q[k-1] + atan_lut(k-1)
                                         : z_q[k-1] - atan_lut(k-1);
            end
            vld_q <= {vld_q[VDEPTH-2:0], inValid};
        end
    end

`ifdef GAIN_COMP_EN
    localparam int PW = MIDWIDTH + 16;
    localparam logic signed [PW-1:0] GAIN = PW'(19898);

    // Multiply by 19898/32768, round to nearest with ties away from zero.
    function automatic logic signed [MIDWIDTH-1:0] gain_comp(
        input logic signed [MIDWIDTH-1:0] v
    );
        logic signed [PW-1:0] prod;
        logic [PW-1:0]        mag;
        logic [PW-1:0]        rnd;
        prod = PW'(v) * GAIN;
        mag  = prod[PW-1] ? -prod : prod;
        rnd  = (mag + PW'(16384)) >> 15;
        gain_comp = prod[PW-1] ? -MIDWIDTH'(rnd) : MIDWIDTH'(rnd);
    endfunction

    logic signed [MIDWIDTH-1:0] fx_q, fy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fx_q <= '0;
            fy_q <= '0;
        end else begin
            fx_q <= x_n[STAGES-1];
            fy_q <= y_n[STAGES-1];
        end
    end

    assign res_x = gain_comp(fx_q);
    assign res_y = gain_comp(fy_q);
`else
    // Last iteration feeds the output register directly to keep latency at STAGES+1.
    assign res_x = x_n[STAGES-1];
    assign res_y = y_n[STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outValid <= 1'b0;
            realOut  <= '0;
            imagOut  <= '0;
        end else begin
            outValid <= vld_q[VDEPTH-1];
            if (vld_q[VDEPTH-1]) begin
                realOut <= OUTWIDTH'(res_x);
                imagOut <= OUTWIDTH'(res_y);
            end
        end
    end

endmodule

// File: tb/tb_polar_to_rect_cordic.sv
// Scoreboard bench for polar_to_rect_cordic: stimulus pushes ideal A*G*cos/sin results,
// a negedge monitor pops and compares whenever outValid is seen.
module tb_polar_to_rect_cordic;

    localparam real PI = 3.14159265358979;
`ifdef GAIN_COMP_EN
    localparam int LAT = 14;
`else
    localparam int LAT = 13;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               inValid = 1'b0;
    logic signed [19:0] ampIn = '0;
    logic signed [14:0] angleIn = '0;
    logic               outValid;
    logic signed [21:0] realOut, imagOut;

    polar_to_rect_cordic dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .ampIn    (ampIn),
        .angleIn  (angleIn),
        .outValid (outValid),
        .realOut  (realOut),
        .imagOut  (imagOut)
    );

    always #5 clk = ~clk;

    int  cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int  tests = 0;
    int  fails = 0;
    real gain;

    real qre[$], qim[$], qtol[$];
    int  qcyc[$];

    real hold_re, hold_im, hold_tol;
    bit  have_hold = 1'b0;

    task automatic chk(input string name, input bit ok, input real act, input real req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0.1f expected %0.1f (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic real absr(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Issue one sample this cycle and record the ideal response.
    task automatic issue(input int a, input int ang);
        real rad;
        ampIn   = 20'(a);
        angleIn = 15'(ang);
        inValid = 1'b1;
        rad = $itor(ang) * PI / 10000.0;
        qre.push_back($itor(a) * gain * $cos(rad));
        qim.push_back($itor(a) * gain * $sin(rad));
        qtol.push_back(0.0015 * $itor(a) * gain);
        qcyc.push_back(cyc);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (qre.size() != 0 && guard < 4 * LAT) begin
            @(posedge clk);
            guard++;
        end
        #1;
        chk("drain", qre.size() == 0, $itor(qre.size()), 0.0);
    endtask

    // Monitor: compare every output strobe against the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (outValid) begin
                if (qre.size() == 0) begin
                    chk("unexpected_outValid", 1'b0, 1.0, 0.0);
                end else begin
                    real er, ei, et;
                    int  ec;
                    er = qre.pop_front();
                    ei = qim.pop_front();
                    et = qtol.pop_front();
                    ec = qcyc.pop_front();
                    chk("real", absr($itor(realOut) - er) <= et, $itor(realOut), er);
                    chk("imag", absr($itor(imagOut) - ei) <= et, $itor(imagOut), ei);
                    chk("latency", (cyc - ec) == LAT, $itor(cyc - ec), $itor(LAT));
                    hold_re   = er;
                    hold_im   = ei;
                    hold_tol  = et;
                    have_hold = 1'b1;
                end
            end else if (have_hold) begin
                chk("hold_real", absr($itor(realOut) - hold_re) <= hold_tol,
                    $itor(realOut), hold_re);
                chk("hold_imag", absr($itor(imagOut) - hold_im) <= hold_tol,
                    $itor(imagOut), hold_im);
            end
        end
    end

    initial begin
`ifdef GAIN_COMP_EN
        gain = 1.0;
`else
        gain = 1.0;
        for (int i = 0; i < 12; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));
`endif
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outValid", outValid == 1'b0, $itor(outValid), 0.0);
        chk("rst_real", realOut == 0, $itor(realOut), 0.0);
        chk("rst_imag", imagOut == 0, $itor(imagOut), 0.0);
        #1;
        rst = 1'b0;
        idle(2);

        // Directed points and boundaries
        issue(100000, 0);
        idle(LAT + 2);
        issue(100000, 5000);
        issue(100000, -5000);
        issue(100000, -7500);
        issue(100000, 10000);
        issue(100000, -10000);
        issue(0, 1234);
        issue(100000, 2500);
        drain();

        // Random legal samples, random gaps
        begin
            int n;
            n = 0;
            while (n < 32) begin
                if ($urandom_range(0, 1) == 1) begin
                    issue(int'($urandom_range(50000, 500000)),
                          int'($urandom_range(0, 20000)) - 10000);
                    n++;
                end else begin
                    idle(1);
                end
            end
        end
        drain();

        // Reset with 5 samples in flight
        for (int i = 0; i < 5; i++) issue(200000, 1000 * i - 2000);
        idle(2);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_outValid", outValid == 1'b0, $itor(outValid), 0.0);
        chk("midrst_real", realOut == 0, $itor(realOut), 0.0);
        chk("midrst_imag", imagOut == 0, $itor(imagOut), 0.0);
        qre.delete();
        qim.delete();
        qtol.delete();
        qcyc.delete();
        have_hold = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        // Any outValid here is flagged by the monitor as unexpected.
        idle(3 * LAT);
        issue(150000, 3333);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got %0d expected 0", 1);
        $fatal(1);
    end

endmodule
